// File: rtl/adxl345_spi_ctrl_if.sv
// Bus-side command/sample interface of the ADXL345 SPI controller.
// master = register/bus logic, slave = adxl345_spi_ctrl.
interface adxl345_spi_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        sample_req;
  logic        auto_en;
  logic        sample_valid;
  logic [15:0] accel_x;
  logic [15:0] accel_y;
  logic [15:0] accel_z;
  logic        busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, sample_req, auto_en,
    input  cmd_ready, rd_valid, rd_data, sample_valid, accel_x, accel_y, accel_z, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, sample_req, auto_en,
    output cmd_ready, rd_valid, rd_data, sample_valid, accel_x, accel_y, accel_z, busy
  );
endinterface

// File: rtl/adxl345_spi_ctrl.sv
// SPI mode-3 master and transaction sequencer for the ADXL345 (register commands + XYZ bursts).
// Optional power-up configuration writes are enabled with `define ADXL345_INIT_EN.
module adxl345_spi_ctrl #(
  parameter int CLK_DIV = 25
) (
  input  logic                      clk,
  input  logic                      reset_n,
  adxl345_spi_ctrl_if.slave         bus,
  output logic                      G_SENSOR_SCLK,
  output logic                      G_SENSOR_nCS,
  output logic                      G_SENSOR_SDA_SDIO,
  input  logic                      G_SENSOR_SDO,
  input  logic                      G_SENSOR_INT
);
  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD, ST_CS_GAP} state_t;
  typedef enum logic [1:0] {K_WRITE, K_READ, K_BURST} kind_t;

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
  localparam logic [15:0]   INIT_W0 = {2'b00, 6'h31, 8'h0B};
  localparam logic [15:0]   INIT_W1 = {2'b00, 6'h2D, 8'h08};

`ifdef ADXL345_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
  localparam bit     INIT_EN   = 1'b1;
`else
  localparam state_t RST_STATE = ST_IDLE;
  localparam bit     INIT_EN   = 1'b0;
`endif

  state_t        state;
  kind_t         kind;
  logic [CW-1:0] cnt;
  logic [5:0]    bit_cnt;
  logic [15:0]   tx_sr;
  logic [47:0]   rx_sr;
  logic [1:0]    init_idx;
  logic          pending;
  logic          int_s1, int_s2, int_s3;
  logic          cmd_ready_q, busy_q, rd_valid_q, sample_valid_q;
  logic [7:0]    rd_data_q;
  logic [15:0]   accel_x_q, accel_y_q, accel_z_q;

  logic          sample_evt;
  logic          launch;
  logic [15:0]   launch_word;
  kind_t         launch_kind;
  logic [5:0]    last_bit;

  assign G_SENSOR_SDA_SDIO = tx_sr[15];
  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.busy          = busy_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.sample_valid  = sample_valid_q;
  assign bus.accel_x       = accel_x_q;
  assign bus.accel_y       = accel_y_q;
  assign bus.accel_z       = accel_z_q;

  always_comb begin
    sample_evt  = bus.sample_req | (bus.auto_en & int_s2 & ~int_s3);
    last_bit    = (kind == K_BURST) ? 6'd55 : 6'd15;
    launch      = 1'b0;
    launch_word = '0;
    launch_kind = K_WRITE;
    if (state == ST_INIT) begin
      launch      = 1'b1;
      launch_word = init_idx[0] ? INIT_W1 : INIT_W0;
    end else if (state == ST_IDLE) begin
      if (bus.cmd_valid && cmd_ready_q) begin
        launch      = 1'b1;
        launch_word = {~bus.cmd_write, 1'b0, bus.cmd_addr, bus.cmd_write ? bus.cmd_wdata : 8'h00};
        launch_kind = bus.cmd_write ? K_WRITE : K_READ;
      end else if (pending) begin
        launch      = 1'b1;
        launch_word = {2'b11, 6'h32, 8'h00};
        launch_kind = K_BURST;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RST_STATE;
      kind           <= K_WRITE;
      cnt            <= '0;
      bit_cnt        <= '0;
      tx_sr          <= '0;
      rx_sr          <= '0;
      init_idx       <= '0;
      pending        <= 1'b0;
      {int_s1, int_s2, int_s3} <= '0;
      G_SENSOR_SCLK  <= 1'b1;
      G_SENSOR_nCS   <= 1'b1;
      cmd_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      rd_valid_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      rd_data_q      <= '0;
      accel_x_q      <= '0;
      accel_y_q      <= '0;
      accel_z_q      <= '0;
    end else begin
      rd_valid_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      int_s1         <= G_SENSOR_INT;
      int_s2         <= int_s1;
      int_s3         <= int_s2;

      if (launch) begin
        state        <= ST_CS_SETUP;
        kind         <= launch_kind;
        tx_sr        <= launch_word;
        G_SENSOR_nCS <= 1'b0;
        cnt          <= '0;
        bit_cnt      <= '0;
        cmd_ready_q  <= 1'b0;
        busy_q       <= 1'b1;
        if (launch_kind == K_BURST) pending <= 1'b0;
        if (state == ST_INIT) init_idx <= init_idx + 2'd1;
      end else begin
        case (state)
          ST_IDLE: begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          ST_CS_SETUP: begin
            if (cnt == LAST) begin
              cnt           <= '0;
              G_SENSOR_SCLK <= 1'b0;
              state         <= ST_SHIFT;
            end else cnt <= cnt + 1'b1;
          end
          ST_SHIFT: begin
            // SCLK level doubles as the half-period phase; the last bit leaves SCLK high.
            if (cnt != LAST) cnt <= cnt + 1'b1;
            else begin
              cnt <= '0;
              if (!G_SENSOR_SCLK) begin
                G_SENSOR_SCLK <= 1'b1;
                rx_sr         <= {rx_sr[46:0], G_SENSOR_SDO};
              end else if (bit_cnt == last_bit) begin
                state <= ST_CS_HOLD;
              end else begin
                G_SENSOR_SCLK <= 1'b0;
                bit_cnt       <= bit_cnt + 6'd1;
                tx_sr         <= {tx_sr[14:0], 1'b0};
              end
            end
          end
          ST_CS_HOLD: begin
            if (cnt == LAST) begin
              cnt          <= '0;
              G_SENSOR_nCS <= 1'b1;
              tx_sr        <= '0;
              state        <= ST_CS_GAP;
              if (kind == K_READ) begin
                rd_data_q  <= rx_sr[7:0];
                rd_valid_q <= 1'b1;
              end else if (kind == K_BURST) begin
                accel_x_q      <= {rx_sr[39:32], rx_sr[47:40]};
                accel_y_q      <= {rx_sr[23:16], rx_sr[31:24]};
                accel_z_q      <= {rx_sr[7:0],   rx_sr[15:8]};
                sample_valid_q <= 1'b1;
              end
            end else cnt <= cnt + 1'b1;
          end
          ST_CS_GAP: begin
            if (cnt == LAST) begin
              cnt <= '0;
              if (INIT_EN && init_idx != 2'd2) state <= ST_INIT;
              else begin
                state       <= ST_IDLE;
                cmd_ready_q <= 1'b1;
                busy_q      <= 1'b0;
              end
            end else cnt <= cnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end

      if (sample_evt) pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_adxl345_spi_ctrl.sv
// Scoreboard bench for adxl345_spi_ctrl: expected SPI frames are queued by the stimulus,
// a monitor sniffs MOSI/nCS and completion pulses and checks them at each frame end.
module tb_adxl345_spi_ctrl;
  localparam int D = 4;

  typedef struct {
    int          kind;      // 0 write, 1 read, 2 burst, 3 aborted
    int          bits;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          low;
    bit          gap_chk;
    logic [7:0]  rd;
    logic [15:0] x, y, z;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sclk, ncs, mosi;
  logic sdo = 1'b0;
  logic sint = 1'b0;

  adxl345_spi_ctrl_if bus();

  adxl345_spi_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .G_SENSOR_SCLK(sclk), .G_SENSOR_nCS(ncs), .G_SENSOR_SDA_SDIO(mosi),
    .G_SENSOR_SDO(sdo), .G_SENSOR_INT(sint)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  frame_t exp_q[$];
  int frames_seen = 0;
  logic [55:0] sdo_stream = '0;
  logic [55:0] cap = '0;
  int bc = 0;
  int sdo_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input int kind, input int bits, input logic [7:0] b0,
                                input logic [7:0] b1, input int low, input bit gap,
                                input logic [7:0] rd, input logic [15:0] x, y, z);
    frame_t f;
    f.kind = kind; f.bits = bits; f.b0 = b0; f.b1 = b1; f.low = low;
    f.gap_chk = gap; f.rd = rd; f.x = x; f.y = y; f.z = z;
    return f;
  endfunction

  // Sensor model: shifts MOSI in on SCLK rise, drives SDO on SCLK fall.
  always @(negedge ncs) begin
    bc = 0; cap = '0; sdo_idx = 0;
  end
  always @(posedge sclk) if (!ncs) begin
    if (bc < 56) cap[55-bc] = mosi;
    bc++;
  end
  always @(negedge sclk) if (!ncs) begin
    sdo = (sdo_idx < 56) ? sdo_stream[55-sdo_idx] : 1'b0;
    sdo_idx++;
  end

  // Monitor
  logic ncs_prev = 1'b1;
  int low_cnt = 0;
  int hi_cnt = 0;
  always @(negedge clk) begin
    frame_t f;
    if (ncs_prev && !ncs) begin
      frames_seen++;
      if (exp_q.size() > 0 && exp_q[0].gap_chk)
        chk("cs_gap_len", (hi_cnt >= D && hi_cnt <= D + 1), 1'b1);
      low_cnt = 1;
    end else if (!ncs) low_cnt++;

    if (!ncs_prev && ncs) begin
      hi_cnt = 1;
      chk("frame_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        if (f.kind != 3) begin
          chk("frame_bits", bc, f.bits);
          chk("mosi_byte0", cap[55:48], f.b0);
          chk("ncs_low_cycles", low_cnt, f.low);
          if (f.kind != 2) chk("mosi_byte1", cap[47:40], f.b1);
        end
        chk("rd_valid_at_end", bus.rd_valid, f.kind == 1);
        chk("sample_valid_at_end", bus.sample_valid, f.kind == 2);
        if (f.kind == 1) chk("rd_data", bus.rd_data, f.rd);
        if (f.kind == 2) begin
          chk("accel_x", bus.accel_x, f.x);
          chk("accel_y", bus.accel_y, f.y);
          chk("accel_z", bus.accel_z, f.z);
        end
      end
    end else begin
      if (ncs) hi_cnt++;
      if (bus.rd_valid || bus.sample_valid) chk("stray_pulse", {bus.rd_valid, bus.sample_valid}, 2'b00);
    end
    ncs_prev = ncs;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin step(1); n++; end
    if (n >= 3000) chk("idle_timeout", exp_q.size(), 0);
  endtask

  task automatic send_cmd(input logic w, input logic [5:0] a, input logic [7:0] d, input logic with_sample);
    int n = 0;
    while (!bus.cmd_ready && n < 2000) begin step(1); n++; end
    if (n >= 2000) chk("cmd_ready_timeout", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    bus.sample_req = with_sample;
    step(1);
    bus.cmd_valid = 1'b0; bus.sample_req = 1'b0; bus.cmd_wdata = 8'hFF;
  endtask

  task automatic after_release();
`ifdef ADXL345_INIT_EN
    exp_q.push_back(mk(0, 16, 8'h31, 8'h0B, 34*D, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 16, 8'h2D, 8'h08, 34*D, 0, 0, 0, 0, 0));
    wait_idle();
    step(1);
    chk("cmd_ready_after_init", bus.cmd_ready, 1'b1);
`else
    step(1);
    chk("cmd_ready_first_clk", bus.cmd_ready, 1'b1);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n, f0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.sample_req = 0; bus.auto_en = 0;

    // Reset values
    step(3);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_ncs", ncs, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pulses", {bus.rd_valid, bus.sample_valid}, 2'b00);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_accel", {bus.accel_x, bus.accel_y, bus.accel_z}, 48'h0);
    reset_n = 1'b1;
    after_release();

    // Write 0x2D = 0x08
    exp_q.push_back(mk(0, 16, 8'h2D, 8'h08, 34*D, 0, 0, 0, 0, 0));
    send_cmd(1'b1, 6'h2D, 8'h08, 1'b0);
    n = 0;
    while (!bus.cmd_ready && n < 1000) begin step(1); n++; end
    chk("accept_to_ready", n, 35*D);
    wait_idle();

    // Read 0x00 returning 0xE5
    sdo_stream = {8'h00, 8'hE5, 40'h0};
    exp_q.push_back(mk(1, 16, 8'h80, 8'h00, 34*D, 0, 8'hE5, 0, 0, 0));
    send_cmd(1'b0, 6'h00, 8'h5A, 1'b0);
    wait_idle();

    // Requested XYZ burst
    sdo_stream = {8'h00, 48'h010203040506};
    exp_q.push_back(mk(2, 56, 8'hF2, 8'h00, 114*D, 0, 0, 16'h0201, 16'h0403, 16'h0605));
    bus.sample_req = 1'b1; step(1); bus.sample_req = 1'b0;
    wait_idle();

    // Three INT edges during one burst merge into a single follow-up
    bus.auto_en = 1'b1;
    f0 = frames_seen;
    exp_q.push_back(mk(2, 56, 8'hF2, 8'h00, 114*D, 0, 0, 16'h0201, 16'h0403, 16'h0605));
    exp_q.push_back(mk(2, 56, 8'hF2, 8'h00, 114*D, 1, 0, 16'h0201, 16'h0403, 16'h0605));
    bus.sample_req = 1'b1; step(1); bus.sample_req = 1'b0;
    n = 0;
    while (ncs && n < 100) begin step(1); n++; end
    for (int i = 0; i < 3; i++) begin
      step(6); sint = 1'b1; step(4); sint = 1'b0;
    end
    wait_idle();
    step(600);
    chk("auto_burst_count", frames_seen - f0, 2);

    // INT ignored with auto_en low
    bus.auto_en = 1'b0;
    f0 = frames_seen;
    step(5); sint = 1'b1; step(4); sint = 1'b0;
    step(600);
    chk("no_auto_burst", frames_seen - f0, 0);

    // Command and sample in the same cycle: command first, then burst
    exp_q.push_back(mk(1, 16, 8'hB2, 8'h00, 34*D, 0, 8'h01, 0, 0, 0));
    exp_q.push_back(mk(2, 56, 8'hF2, 8'h00, 114*D, 1, 0, 16'h0201, 16'h0403, 16'h0605));
    send_cmd(1'b0, 6'h32, 8'h00, 1'b1);
    wait_idle();

    // Reset mid-SHIFT discards the frame
    exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    send_cmd(1'b0, 6'h00, 8'h00, 1'b0);
    n = 0;
    while (sclk && n < 200) begin step(1); n++; end
    step(10);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_ncs", ncs, 1'b1);
    chk("abort_sclk", sclk, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_cmd_ready", bus.cmd_ready, 1'b0);
    step(3);
    reset_n = 1'b1;
    after_release();

    // Recovery read
    sdo_stream = {8'h00, 8'h3C, 40'h0};
    exp_q.push_back(mk(1, 16, 8'h80, 8'h00, 34*D, 0, 8'h3C, 0, 0, 0));
    send_cmd(1'b0, 6'h00, 8'h00, 1'b0);
    wait_idle();
    step(20);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
